// File: rtl/reed_solomon_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reed_solomon_decoder_pkg
// Description : Shared types and constants for the Reed-Solomon decoder slice.
// Revision    : 1.0 - initial release (line packer support)
// ============================================================================
package reed_solomon_decoder_pkg;

    typedef enum logic [1:0] {
        S_PK_IDLE  = 2'd0,
        S_PK_FILL  = 2'd1,
        S_PK_DRAIN = 2'd2,
        S_PK_DONE  = 2'd3
    } t_pk_state;

    localparam int PK_LINE_BITS = 512;

    typedef logic [PK_LINE_BITS-1:0] t_line;

endpackage
`default_nettype wire

// File: rtl/reed_solomon_decoder_line_fifo.sv
`default_nettype none
// ============================================================================
// Module      : reed_solomon_decoder_line_fifo
// Description : Small completed-line FIFO; head is shown combinationally,
//               zero when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module reed_solomon_decoder_line_fifo
    import reed_solomon_decoder_pkg::*;
#(
    parameter int WIDTH = PK_LINE_BITS,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     not_full,
    output logic                     not_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign not_empty = (r_count != '0);
    assign not_full  = (r_count != c_CNT_W'(DEPTH));
    assign count     = r_count;
    assign w_do_pop  = pop && not_empty;
    assign w_do_push = push && not_full;
    assign pop_data  = not_empty ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/reed_solomon_decoder_line_packer.sv
`default_nettype none
// ============================================================================
// Module      : reed_solomon_decoder_line_packer
// Description : Packs decoded 8-bit symbols into cache lines, buffers them and
//               reports stream completion. Optional lane reversal via
//               REED_SOLOMON_DECODER_PACKER_BYTE_SWAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module reed_solomon_decoder_line_packer
    import reed_solomon_decoder_pkg::*;
#(
    parameter int LINE_BYTES     = 64,
    parameter int OUT_FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [7:0]                sym_data,
    input  logic                      sym_valid,
    input  logic                      sym_last,
    output logic                      sym_ready,
    input  logic                      line_ready,
    output logic [LINE_BYTES*8-1:0]   data_out,
    output logic                      valid_out,
    output logic [31:0]               line_count,
    output logic                      done
);

    localparam int              c_IDX_W    = $clog2(LINE_BYTES);
    localparam int              c_LINE_W   = LINE_BYTES * 8;
    localparam int              c_CNT_W    = $clog2(OUT_FIFO_DEPTH) + 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(LINE_BYTES - 1);

    t_pk_state            r_state;
    t_pk_state            w_state_next;
    logic [c_IDX_W-1:0]   r_index;
    logic [c_IDX_W-1:0]   w_lane;
    logic [c_LINE_W-1:0]  r_assembly;
    logic [c_LINE_W-1:0]  w_merged;
    logic [c_CNT_W-1:0]   w_fifo_count;
    logic                 w_not_full;
    logic                 w_not_empty;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_start_ok;
    logic                 w_set_done;
    logic                 w_drained;
    logic [31:0]          r_line_count;
    logic                 r_done;

    assign sym_ready  = (r_state == S_PK_FILL) && (w_fifo_count < c_CNT_W'(OUT_FIFO_DEPTH));
    assign w_accept   = sym_valid && sym_ready;
    assign w_push     = w_accept && ((r_index == c_LAST_IDX) || sym_last);
    assign w_pop      = w_not_empty && line_ready;
    assign valid_out  = w_pop;
    assign line_count = r_line_count;
    assign done       = r_done;
    // The final pop empties the FIFO, so completion is recognised one cycle early
    // and done is visible the cycle right after that pop.
    assign w_drained  = !w_not_empty || ((w_fifo_count == c_CNT_W'(1)) && w_pop);

`ifdef REED_SOLOMON_DECODER_PACKER_BYTE_SWAP_EN
    assign w_lane = c_LAST_IDX - r_index;
`else
    assign w_lane = r_index;
`endif

    always_comb begin
        w_merged = r_assembly;
        w_merged[{w_lane, 3'b000} +: 8] = sym_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_PK_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start_ok   = 1'b0;
        w_set_done   = 1'b0;
        case (r_state)
            S_PK_IDLE, S_PK_DONE: begin
                if (start) begin
                    w_state_next = S_PK_FILL;
                    w_start_ok   = 1'b1;
                end
            end
            S_PK_FILL: begin
                if (w_accept && sym_last) begin
                    w_state_next = S_PK_DRAIN;
                end
            end
            S_PK_DRAIN: begin
                if (w_drained) begin
                    w_state_next = S_PK_DONE;
                    w_set_done   = 1'b1;
                end
            end
            default: w_state_next = S_PK_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_index      <= '0;
            r_assembly   <= '0;
            r_line_count <= '0;
            r_done       <= 1'b0;
        end else begin
            if (w_start_ok || w_push) begin
                r_index    <= '0;
                r_assembly <= '0;
            end else if (w_accept) begin
                r_index    <= r_index + 1'b1;
                r_assembly <= w_merged;
            end

            if (w_start_ok) begin
                r_line_count <= '0;
            end else if (w_pop) begin
                r_line_count <= r_line_count + 32'd1;
            end

            if (w_start_ok) begin
                r_done <= 1'b0;
            end else if (w_set_done) begin
                r_done <= 1'b1;
            end
        end
    end

    reed_solomon_decoder_line_fifo #(
        .WIDTH (c_LINE_W),
        .DEPTH (OUT_FIFO_DEPTH)
    ) u_line_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data (w_merged),
        .pop       (w_pop),
        .pop_data  (data_out),
        .count     (w_fifo_count),
        .not_full  (w_not_full),
        .not_empty (w_not_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_reed_solomon_decoder_line_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reed_solomon_decoder_line_packer
// Description : Scoreboard bench for the line packer: stimulus pushes expected
//               lines, a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reed_solomon_decoder_line_packer;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   sym_data = 8'h00;
    logic         sym_valid = 1'b0;
    logic         sym_last = 1'b0;
    logic         sym_ready;
    logic         line_ready = 1'b0;
    logic [511:0] data_out;
    logic         valid_out;
    logic [31:0]  line_count;
    logic         done;

    int           n_vec = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           last_pop_cyc = -100;
    logic [511:0] exp_q[$];
    logic [511:0] m_line = '0;
    int           m_idx = 0;

    reed_solomon_decoder_line_packer #(
        .LINE_BYTES     (64),
        .OUT_FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .sym_data   (sym_data),
        .sym_valid  (sym_valid),
        .sym_last   (sym_last),
        .sym_ready  (sym_ready),
        .line_ready (line_ready),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .line_count (line_count),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every valid_out cycle transfers the head line.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_line: got %h want none", data_out);
            end else begin
                chk("line", data_out, exp_q.pop_front());
            end
            last_pop_cyc = cyc;
        end
    end

    task automatic model_clear();
        m_line = '0;
        m_idx  = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk) #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        @(negedge clk);
        chk("ready_after_start", 512'(sym_ready), 512'd1);
        @(posedge clk) #1;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send_sym(input logic [7:0] d, input logic last);
        bit ok;
        int w;
        ok = 1'b0;
        w  = 0;
        sym_valid = 1'b1;
        sym_data  = d;
        sym_last  = last;
        while (!ok && w < 2000) begin
            @(negedge clk);
            ok = sym_ready;
            @(posedge clk);
            w++;
        end
        #1;
        sym_valid = 1'b0;
        sym_last  = 1'b0;
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: got sym_ready 0 want 1");
        end else begin
`ifdef REED_SOLOMON_DECODER_PACKER_BYTE_SWAP_EN
            m_line[(63 - m_idx) * 8 +: 8] = d;
`else
            m_line[m_idx * 8 +: 8] = d;
`endif
            m_idx++;
            if (m_idx == 64 || last) begin
                exp_q.push_back(m_line);
                model_clear();
            end
        end
    endtask

    task automatic wait_done(input int exp_lines);
        int w;
        w = 0;
        while (done !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("done", 512'(done), 512'd1);
        chk("done_timing", 512'(cyc), 512'(last_pop_cyc + 1));
        chk("line_count", 512'(line_count), 512'(exp_lines));
        @(posedge clk) #1;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_sym_ready", 512'(sym_ready), 512'd0);
        chk("rst_valid_out", 512'(valid_out), 512'd0);
        chk("rst_data_out", data_out, 512'd0);
        chk("rst_line_count", 512'(line_count), 512'd0);
        chk("rst_done", 512'(done), 512'd0);
        @(posedge clk) #1 reset_n = 1'b1;

        // Contiguous stream: two full lines, byte k = k
        line_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 128; i++) send_sym(8'(i), i == 127);
        wait_done(2);

        // Short stream with zero padding
        pulse_start();
        send_sym(8'hAA, 1'b0);
        send_sym(8'hBB, 1'b0);
        send_sym(8'hCC, 1'b1);
        wait_done(1);

        // Backpressure: four lines fill the FIFO, fifth stalls
        line_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 256; i++) send_sym(8'(i * 7 + 3), 1'b0);
        @(negedge clk);
        chk("bp_ready_low", 512'(sym_ready), 512'd0);
        chk("bp_no_valid", 512'(valid_out), 512'd0);
        @(posedge clk) #1;
        fork
            begin
                for (int i = 256; i < 320; i++) send_sym(8'(i * 7 + 3), i == 319);
            end
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                chk("bp_still_stalled", 512'(sym_ready), 512'd0);
                @(posedge clk) #1 line_ready = 1'b1;
            end
        join
        wait_done(5);

        // Simultaneous push and pop with one line held
        line_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 127; i++) send_sym(8'(255 - i), 1'b0);
        line_ready = 1'b1;
        send_sym(8'(255 - 127), 1'b1);
        @(negedge clk);
        chk("pushpop_valid_held", 512'(valid_out), 512'd1);
        wait_done(2);

        // Reset mid-stream
        pulse_start();
        for (int i = 0; i < 40; i++) send_sym(8'(i + 9), 1'b0);
        reset_n = 1'b0;
        model_clear();
        @(negedge clk);
        chk("mid_rst_sym_ready", 512'(sym_ready), 512'd0);
        chk("mid_rst_valid_out", 512'(valid_out), 512'd0);
        chk("mid_rst_data_out", data_out, 512'd0);
        chk("mid_rst_line_count", 512'(line_count), 512'd0);
        chk("mid_rst_done", 512'(done), 512'd0);
        @(posedge clk) #1 reset_n = 1'b1;
        pulse_start();
        for (int i = 0; i < 64; i++) send_sym(8'(i + 100), i == 63);
        wait_done(1);

        // Single-symbol stream; lands in the lane chosen by the build option
        pulse_start();
        send_sym(8'h5A, 1'b1);
        wait_done(1);

        chk("scoreboard_empty", 512'(exp_q.size()), 512'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
